// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the RV32I multi-cycle core: ALU operation
// codes, control FSM states, decoded instruction classes and major opcodes.
// Imported by the control FSM, the decoder, the ALU and the testbenches.
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } ctrl_state_t;

  // R-type and OP-IMM share one class; they differ only in alu_src_b.
  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_SYSTEM = 2'd3
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Only word-sized loads and stores are implemented.
  localparam logic [2:0] F3_WORD   = 3'b010;

  // funct3 -> ALU operation. sub_en selects SUB for funct3=000 (R-type with
  // funct7[5] set). funct3=011 has no mapping; the caller flags it illegal.
  function automatic alu_op_t funct3_to_alu(input logic [2:0] f3,
                                            input logic       sub_en);
    alu_op_t op;
    case (f3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b001:  op = ALU_SLL;
      3'b101:  op = ALU_SRL;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Request/ready handshake between the control FSM and data memory.
//   dmem_req   : access request, high for every cycle of the access
//   dmem_we    : access is a store (qualified by dmem_req)
//   dmem_ready : memory has completed the current access
// Handshake: an access completes on the rising edge where dmem_req and
// dmem_ready are both high. Once raised, dmem_req stays high until that edge
// (only reset can drop it early). dmem_ready is ignored while dmem_req is low.
// Modports: master = control FSM, slave = data memory.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output dmem_req, output dmem_we, input dmem_ready);
  modport slave  (input dmem_req, input dmem_we, output dmem_ready);
endinterface

// File: rtl/multicycle_control_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational decode of the latched instruction register.
// Ports:
//   i_ir          in  32  instruction register contents
//   o_class       out     instruction class (ALU / LOAD / STORE / SYSTEM)
//   o_alu_op      out     ALU operation for EXEC and MEM
//   o_alu_src_b   out     ALU B operand: 0 = rs2, 1 = immediate
//   o_illegal     out     unsupported opcode or funct3
//   o_rd_is_zero  out     destination register is x0
// -----------------------------------------------------------------------------
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0]  i_ir,
  output instr_class_t o_class,
  output alu_op_t      o_alu_op,
  output logic         o_alu_src_b,
  output logic         o_illegal,
  output logic         o_rd_is_zero
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7_b5;
  logic       w_unused_ir;

  assign w_opcode     = i_ir[6:0];
  assign w_funct3     = i_ir[14:12];
  assign w_funct7_b5  = i_ir[30];
  assign o_rd_is_zero = (i_ir[11:7] == 5'd0);
  // Register specifiers and immediates belong to the datapath, not control.
  assign w_unused_ir  = ^{i_ir[31], i_ir[29:15]};

  always_comb begin
    o_class     = CLS_SYSTEM;
    o_alu_op    = ALU_ADD;
    o_alu_src_b = 1'b0;
    o_illegal   = 1'b0;
    case (w_opcode)
      OP_R: begin
        o_class   = CLS_ALU;
        o_alu_op  = funct3_to_alu(w_funct3, w_funct7_b5);
        o_illegal = (w_funct3 == 3'b011);
      end
      OP_IMM: begin
        // No SUBI: bit 30 is part of the immediate here.
        o_class     = CLS_ALU;
        o_alu_op    = funct3_to_alu(w_funct3, 1'b0);
        o_alu_src_b = 1'b1;
        o_illegal   = (w_funct3 == 3'b011);
      end
      OP_LOAD: begin
        o_class     = CLS_LOAD;
        o_alu_src_b = 1'b1;
        o_illegal   = (w_funct3 != F3_WORD);
      end
      OP_STORE: begin
        o_class     = CLS_STORE;
        o_alu_src_b = 1'b1;
        o_illegal   = (w_funct3 != F3_WORD);
      end
      OP_SYSTEM: begin
        o_class = CLS_SYSTEM;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle control FSM for the RV32I core. Owns the instruction register,
// sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable/select.
// Ports:
//   clk          in        rising-edge clock
//   reset        in        asynchronous active-low reset
//   run          in        start request, sampled only in IDLE
//   instruction  in  32    instruction-memory output for the current PC
//   dmem         master    data-memory request/ready handshake
//   ir_write     out       latch instruction into the IR (FETCH)
//   pc_write     out       advance PC; marks the retiring cycle
//   reg_write    out       register-file write (WB, not for rd=x0)
//   alu_op       out  3    ALU operation (EXEC, MEM)
//   alu_src_b    out       ALU B select (EXEC, MEM)
//   wb_sel       out       writeback source: 1 = load data (WB)
//   halted       out       core stopped on ECALL or illegal instruction
//   illegal      out       stop was caused by an illegal instruction
//   retired      out  RW   retired-instruction count, wraps
//   dbg_state    out       current FSM state
// -----------------------------------------------------------------------------
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [31:0]           instruction,
  multicycle_control_if.master  dmem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output alu_op_t               alu_op,
  output logic                  alu_src_b,
  output logic                  wb_sel,
  output logic                  halted,
  output logic                  illegal,
  output logic [RETIRE_W-1:0]   retired,
  output ctrl_state_t           dbg_state
);

  ctrl_state_t         r_state;
  ctrl_state_t         w_next_state;
  logic [31:0]         r_ir;
  logic                r_illegal;
  logic [RETIRE_W-1:0] r_retired;

  logic                w_retire;
  logic                w_enter_halt;

  instr_class_t        w_dec_class;
  alu_op_t             w_dec_alu_op;
  logic                w_dec_alu_src_b;
  logic                w_dec_illegal;
  logic                w_dec_rd_is_zero;

  instr_decode u_decode (
    .i_ir         (r_ir),
    .o_class      (w_dec_class),
    .o_alu_op     (w_dec_alu_op),
    .o_alu_src_b  (w_dec_alu_src_b),
    .o_illegal    (w_dec_illegal),
    .o_rd_is_zero (w_dec_rd_is_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ir      <= 32'd0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (ir_write) begin
        r_ir <= instruction;
      end
      // Only written on the way into HALT, so the cause stays sticky there.
      if (w_enter_halt) begin
        r_illegal <= w_dec_illegal;
      end
      if (w_retire) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_b     = 1'b0;
    wb_sel        = 1'b0;
    dmem.dmem_req = 1'b0;
    dmem.dmem_we  = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;
    w_retire      = 1'b0;
    w_enter_halt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_write     = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        if (w_dec_illegal || (w_dec_class == CLS_SYSTEM)) begin
          w_enter_halt = 1'b1;
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op    = w_dec_alu_op;
        alu_src_b = w_dec_alu_src_b;
        if ((w_dec_class == CLS_LOAD) || (w_dec_class == CLS_STORE)) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        // ALU keeps computing the address so the datapath sees it stable.
        alu_op        = w_dec_alu_op;
        alu_src_b     = w_dec_alu_src_b;
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = (w_dec_class == CLS_STORE);
        if (dmem.dmem_ready) begin
          if (w_dec_class == CLS_STORE) begin
            // A store has no writeback; it retires on its completing cycle.
            pc_write     = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write    = !w_dec_rd_is_zero;
        wb_sel       = (w_dec_class == CLS_LOAD);
        pc_write     = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        illegal = r_illegal;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign retired   = r_retired;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control: directed table of instructions
// with hand-derived per-instruction results, randomized instructions checked
// against a per-instruction reference model, and hand-written cycle-level
// sequences (add timing, sticky halt, reset in the middle of a memory access).
// -----------------------------------------------------------------------------
module tb_multicycle_control;
  import cpu_pkg::*;

  localparam int RW = 4;  // small counter so wrap-around is exercised

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic           run;
  logic [31:0]    instruction;
  logic           ir_write, pc_write, reg_write, alu_src_b, wb_sel;
  logic           halted, illegal;
  alu_op_t        alu_op;
  logic [RW-1:0]  retired;
  ctrl_state_t    dbg_state;

  multicycle_control_if dmem_if ();

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .dmem        (dmem_if),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .alu_op      (alu_op),
    .alu_src_b   (alu_src_b),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int exp_retired = 0;

  // Per-instruction summary: latency FETCH->next FETCH (or FETCH->HALT),
  // counts of each strobe, halt cause and the ALU controls seen in EXEC.
  typedef struct {
    int lat; int n_pc; int n_reg; int n_wbsel; int n_req; int n_we;
    int halt; int ill; int alu; int srcb;
  } res_t;

  typedef struct {
    logic [31:0] ins;
    int          n_wait;
    res_t        exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic res_t model(input logic [31:0] ins, input int n);
    res_t r;
    alu_op_t f3_map [8];
    logic [6:0] opc;
    logic [2:0] f3;
    int wr;
    f3_map = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_ADD, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc = ins[6:0];
    f3  = ins[14:12];
    wr  = (ins[11:7] != 5'd0) ? 1 : 0;
    r = '{default: 0};
    case (opc)
      7'b0110011, 7'b0010011: begin
        if (f3 == 3'b011) r.ill = 1;
        else begin
          r.lat = 4; r.n_pc = 1; r.n_reg = wr;
          r.srcb = (opc == 7'b0010011) ? 1 : 0;
          r.alu  = f3_map[f3];
          if (opc == 7'b0110011 && f3 == 3'b000 && ins[30]) r.alu = ALU_SUB;
        end
      end
      7'b0000011: begin
        if (f3 != 3'b010) r.ill = 1;
        else begin
          r.lat = 5 + n; r.n_pc = 1; r.n_reg = wr; r.n_wbsel = 1;
          r.n_req = n + 1; r.alu = ALU_ADD; r.srcb = 1;
        end
      end
      7'b0100011: begin
        if (f3 != 3'b010) r.ill = 1;
        else begin
          r.lat = 4 + n; r.n_pc = 1; r.n_req = n + 1; r.n_we = n + 1;
          r.alu = ALU_ADD; r.srcb = 1;
        end
      end
      7'b1110011: r.halt = 1;
      default:    r.ill = 1;
    endcase
    if (r.ill != 0) r.halt = 1;
    if (r.halt != 0) r.lat = 2;  // FETCH, DECODE, then HALT is visible
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 19);
    if (k < 5)       w[6:0] = 7'b0110011;
    else if (k < 9)  w[6:0] = 7'b0010011;
    else if (k < 13) w[6:0] = 7'b0000011;
    else if (k < 17) w[6:0] = 7'b0100011;
    else if (k < 18) w[6:0] = 7'b1110011;
    if (k >= 9 && k < 17 && $urandom_range(0, 3) != 0) w[14:12] = 3'b010;
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Reset, confirm idle state, then start and stop at the first FETCH cycle.
  task automatic start();
    logic seen;
    reset = 1'b0; run = 1'b0; instruction = 32'd0; dmem_if.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_retired", retired, 0);
    chk("rst_outputs", {ir_write, pc_write, reg_write, alu_op, alu_src_b, wb_sel,
                        dmem_if.dmem_req, dmem_if.dmem_we, halted, illegal}, 0);
    reset = 1'b1;
    exp_retired = 0;
    step();
    step();
    chk("idle_without_run", dbg_state, S_IDLE);
    run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ir_write) begin
        seen = 1'b1;
        break;
      end
    end
    chk("start_fetch", seen, 1);
  endtask

  // Called in a FETCH cycle; runs one instruction until the next FETCH or HALT.
  // dmem_ready is low for n_wait MEM cycles then high; outside MEM it and run
  // are randomized to show they are ignored.
  task automatic exec_instr(input logic [31:0] ins, input int n_wait,
                            output res_t o, output int unstable);
    int  mem_cyc;
    logic done;
    mem_cyc  = 0;
    done     = 1'b0;
    unstable = 0;
    o = '{default: 0};
    o.lat = -1;
    instruction = ins;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      if (dmem_if.dmem_req) begin
        mem_cyc++;
        dmem_if.dmem_ready = (mem_cyc > n_wait);
      end else begin
        dmem_if.dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (ir_write || halted) begin
        o.lat  = cyc;
        o.halt = int'(halted);
        o.ill  = int'(illegal);
        done   = 1'b1;
      end else begin
        if (cyc == 2) begin
          o.alu  = int'(alu_op);
          o.srcb = int'(alu_src_b);
        end
        o.n_pc    += int'(pc_write);
        o.n_reg   += int'(reg_write);
        o.n_wbsel += int'(wb_sel);
        o.n_req   += int'(dmem_if.dmem_req);
        o.n_we    += int'(dmem_if.dmem_we);
        if (dmem_if.dmem_req && (int'(alu_op) != o.alu || int'(alu_src_b) != o.srcb))
          unstable++;
      end
    end
  endtask

  task automatic check_instr(input string tag, input logic [31:0] ins,
                             input int n_wait, input res_t e);
    res_t o;
    int   unstable;
    exec_instr(ins, n_wait, o, unstable);
    chk({tag, "_lat"},      o.lat,     e.lat);
    chk({tag, "_pc_write"}, o.n_pc,    e.n_pc);
    chk({tag, "_reg_write"},o.n_reg,   e.n_reg);
    chk({tag, "_wb_sel"},   o.n_wbsel, e.n_wbsel);
    chk({tag, "_dmem_req"}, o.n_req,   e.n_req);
    chk({tag, "_dmem_we"},  o.n_we,    e.n_we);
    chk({tag, "_halted"},   o.halt,    e.halt);
    chk({tag, "_illegal"},  o.ill,     e.ill);
    chk({tag, "_alu_op"},   o.alu,     e.alu);
    chk({tag, "_alu_src_b"},o.srcb,    e.srcb);
    chk({tag, "_alu_stable"}, unstable, 0);
    if (e.halt == 0) exp_retired = (exp_retired + 1) % (1 << RW);
    chk({tag, "_retired"}, retired, exp_retired);
    if (e.halt != 0) start();
  endtask

  // ---------------- main test ----------------
  vec_t tbl [$];

  initial begin
    tbl.push_back('{32'h00412283, 2, '{7, 1, 1, 1, 3, 0, 0, 0, ALU_ADD, 1}}); // lw, 2 waits
    tbl.push_back('{32'h00512223, 0, '{4, 1, 0, 0, 1, 1, 0, 0, ALU_ADD, 1}}); // sw, ready now
    tbl.push_back('{32'h00000013, 0, '{4, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, 1}}); // addi x0
    tbl.push_back('{32'h403100b3, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_SUB, 0}}); // sub
    tbl.push_back('{32'h0ff1f193, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_AND, 1}}); // andi
    tbl.push_back('{32'h0062a233, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_SLT, 0}}); // slt
    tbl.push_back('{32'h4062d233, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_SRL, 0}}); // f7[5] srl
    tbl.push_back('{32'h00309093, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_SLL, 1}}); // slli
    tbl.push_back('{32'h40000093, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_ADD, 1}}); // addi, imm bit30
    tbl.push_back('{32'h0062c233, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_XOR, 0}}); // xor
    tbl.push_back('{32'h0062e233, 0, '{4, 1, 1, 0, 0, 0, 0, 0, ALU_OR,  0}}); // or
    tbl.push_back('{32'h00412283, 0, '{5, 1, 1, 1, 1, 0, 0, 0, ALU_ADD, 1}}); // lw, no wait
    tbl.push_back('{32'h00512223, 3, '{7, 1, 0, 0, 4, 4, 0, 0, ALU_ADD, 1}}); // sw, 3 waits
    tbl.push_back('{32'h00012003, 1, '{6, 1, 0, 1, 2, 0, 0, 0, ALU_ADD, 1}}); // lw x0
    tbl.push_back('{32'h00000000, 0, '{2, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, 0}}); // illegal
    tbl.push_back('{32'h00000073, 0, '{2, 0, 0, 0, 0, 0, 1, 0, ALU_ADD, 0}}); // ecall
    tbl.push_back('{32'h0062b233, 0, '{2, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, 0}}); // R f3=011
    tbl.push_back('{32'h00411283, 0, '{2, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, 0}}); // lh
    tbl.push_back('{32'h00003013, 0, '{2, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, 0}}); // sltiu

    start();

    // add x7,x6,x5 cycle by cycle; cycle 1 is the FETCH we are in now.
    chk("add_c1_ir_write", ir_write, 1);
    chk("add_c1_state", dbg_state, S_FETCH);
    instruction = 32'h005303b3;
    run = 1'b0;
    step();
    chk("add_c2_quiet", {ir_write, pc_write, reg_write, dmem_if.dmem_req, halted}, 0);
    step();
    chk("add_c3_alu_op", alu_op, ALU_ADD);
    chk("add_c3_alu_src_b", alu_src_b, 0);
    chk("add_c3_state", dbg_state, S_EXEC);
    chk("add_c3_no_write", {reg_write, pc_write}, 0);
    step();
    chk("add_c4_reg_write", reg_write, 1);
    chk("add_c4_pc_write", pc_write, 1);
    chk("add_c4_wb_sel", wb_sel, 0);
    step();
    chk("add_c5_ir_write", ir_write, 1);
    chk("add_retired", retired, 1);
    exp_retired = 1;

    foreach (tbl[i]) begin
      check_instr($sformatf("vec%0d", i), tbl[i].ins, tbl[i].n_wait, tbl[i].exp);
    end

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ins;
      int n;
      ins = rand_instr();
      n   = $urandom_range(0, 3);
      check_instr($sformatf("rnd%0d_%08h", i, ins), ins, n, model(ins, n));
    end

    // Sticky halt: ECALL, then HALT must hold whatever run/ready do.
    begin
      res_t o;
      int unstable;
      exec_instr(32'h00000073, 0, o, unstable);
      chk("ecall_halted", o.halt, 1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        run = 1'($urandom_range(0, 1));
        dmem_if.dmem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("halt_sticky_state", dbg_state, S_HALT);
        chk("halt_sticky_flags", {halted, illegal}, 2'b10);
        chk("halt_no_activity", {ir_write, pc_write, reg_write, dmem_if.dmem_req}, 0);
      end
    end

    // Reset during a stalled load.
    start();
    check_instr("pre_reset_add", 32'h005303b3, 0, model(32'h005303b3, 0));
    instruction = 32'h00412283;
    dmem_if.dmem_ready = 1'b0;
    step();  // DECODE
    step();  // EXEC
    step();  // MEM
    chk("mid_mem_req", dmem_if.dmem_req, 1);
    chk("mid_mem_retired", retired, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_req", dmem_if.dmem_req, 0);
    chk("async_rst_state", dbg_state, S_IDLE);
    chk("async_rst_retired", retired, 0);
    chk("async_rst_outputs", {ir_write, pc_write, reg_write, alu_op, alu_src_b, wb_sel,
                              dmem_if.dmem_we, halted, illegal}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
